// File: rtl/cardinal_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_mem_pkg
// Purpose  : Shared defaults, FSM state encoding and byte-lane helpers for
//            the Cardinal data-memory responder.
// Revision : 1.0  initial release
// ============================================================================
package cardinal_mem_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 64;

  // Number of bytes in a word; one parity bit is kept per byte lane.
  function automatic int unsigned lane_count(input int unsigned dw);
    return dw / 8;
  endfunction

  localparam int unsigned DMEM_LANES = lane_count(DMEM_DATA_W);

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01,
    HOST  = 2'b10
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/cardinal_dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_dmem_if
// Purpose  : Processor Dmem bus plus host preload/dump port of the Cardinal
//            data memory. master = processor/host side, slave = memory.
//            Parity signals exist only when CARDINAL_DMEM_PARITY_EN is set.
// Revision : 1.0  initial release
// ============================================================================
interface cardinal_dmem_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
);
  // Processor side
  logic              DmemEn;
  logic              DmemWrEn;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Data_In;
  logic [DATA_W-1:0] Data_Out;
  logic              Rd_Valid;
  logic              Ready;
  logic              Drop_Err;
  // Host side
  logic              Host_Req;
  logic              Host_We;
  logic [ADDR_W-1:0] Host_Addr;
  logic [DATA_W-1:0] Host_Wdata;
  logic [DATA_W-1:0] Host_Rdata;
  logic              Host_Ack;
`ifdef CARDINAL_DMEM_PARITY_EN
  logic              Par_Inject;
  logic              Par_Err;
`endif

  modport master (
    output DmemEn, DmemWrEn, Mem_Addr, Data_In,
    output Host_Req, Host_We, Host_Addr, Host_Wdata,
`ifdef CARDINAL_DMEM_PARITY_EN
    output Par_Inject,
    input  Par_Err,
`endif
    input  Data_Out, Rd_Valid, Ready, Drop_Err, Host_Rdata, Host_Ack
  );

  modport slave (
    input  DmemEn, DmemWrEn, Mem_Addr, Data_In,
    input  Host_Req, Host_We, Host_Addr, Host_Wdata,
`ifdef CARDINAL_DMEM_PARITY_EN
    input  Par_Inject,
    output Par_Err,
`endif
    output Data_Out, Rd_Valid, Ready, Drop_Err, Host_Rdata, Host_Ack
  );

endinterface
`default_nettype wire

// File: rtl/cardinal_dmem_parity_gen.sv
`default_nettype none
// ============================================================================
// Module   : dmem_parity_gen
// Purpose  : Combinational even parity, one bit per byte lane. A lane's bit
//            makes the lane plus its parity bit contain an even number of 1s.
// Revision : 1.0  initial release
// ============================================================================
module dmem_parity_gen #(
  parameter int unsigned DATA_W = 64
) (
  input  wire logic [DATA_W-1:0]   i_data,
  output logic      [DATA_W/8-1:0] o_parity
);

  for (genvar g = 0; g < DATA_W / 8; g++) begin : g_lane
    assign o_parity[g] = ^i_data[g*8 +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/cardinal_dmem.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_dmem
// Purpose  : Data-memory responder for the Cardinal pipeline. Single-port
//            array with registered reads, a post-reset clear engine, and a
//            host port that only gets the array when the processor is idle.
//            Optional per-byte parity: define CARDINAL_DMEM_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module cardinal_dmem
  import cardinal_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned CLR_PER_CYC = 1
) (
  input wire logic       Clock,
  input wire logic       Reset,
  cardinal_dmem_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Array contents are never reset; the CLEAR state zeroes them instead.
  logic [DATA_W-1:0] r_mem [DEPTH];

  dmem_state_t       r_state;
  dmem_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic              w_ready;
  logic              w_proc_go;
  logic              w_proc_rd;
  logic              w_host_go;
  logic              w_host_rd;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_host_ack;
  logic              r_drop_err;

  // Processor wins the single port every cycle it asks; the host only
  // executes in HOST with the processor quiet.
  assign w_ready   = (r_state != CLEAR);
  assign w_proc_go = w_ready & bus.DmemEn;
  assign w_proc_rd = w_proc_go & ~bus.DmemWrEn;
  assign w_host_go = (r_state == HOST) & ~bus.DmemEn;
  assign w_host_rd = w_host_go & ~bus.Host_We;
  assign w_rdata   = r_mem[w_addr];

  // Single-port address/write mux: clear engine, then processor, then host.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = r_clr_cnt;
    w_wdata = '0;
    if (r_state == CLEAR) begin
      w_we = 1'b1;
    end else if (w_proc_go) begin
      w_we    = bus.DmemWrEn;
      w_addr  = bus.Mem_Addr;
      w_wdata = bus.Data_In;
    end else if (w_host_go) begin
      w_we    = bus.Host_We;
      w_addr  = bus.Host_Addr;
      w_wdata = bus.Host_Wdata;
    end
  end

  // Next-state logic; HOST waits out any processor burst before executing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_clr_cnt == '1) w_state_nxt = IDLE;
      IDLE:    if (!bus.DmemEn && bus.Host_Req) w_state_nxt = HOST;
      HOST:    if (!bus.DmemEn) w_state_nxt = IDLE;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // State register and clear counter; reset restarts clearing at address 0.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + ADDR_W'(CLR_PER_CYC);
    end
  end

  // Storage write port.
  always_ff @(posedge Clock) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
  end

  // Registered read data, completion strobes and the sticky drop flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_data_out   <= '0;
      r_rd_valid   <= 1'b0;
      r_host_rdata <= '0;
      r_host_ack   <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_proc_rd;
      r_host_ack <= w_host_go;
      if (w_proc_rd) r_data_out <= w_rdata;
      if (w_host_rd) r_host_rdata <= w_rdata;
      if (bus.DmemEn && !w_ready) r_drop_err <= 1'b1;
    end
  end

  assign bus.Ready      = w_ready;
  assign bus.Data_Out   = r_data_out;
  assign bus.Rd_Valid   = r_rd_valid;
  assign bus.Host_Rdata = r_host_rdata;
  assign bus.Host_Ack   = r_host_ack;
  assign bus.Drop_Err   = r_drop_err;

`ifdef CARDINAL_DMEM_PARITY_EN
  localparam int unsigned LANES = lane_count(DATA_W);

  logic [LANES-1:0] r_par_mem [DEPTH];
  logic [LANES-1:0] w_wpar_gen;
  logic [LANES-1:0] w_rpar_gen;
  logic [LANES-1:0] w_wpar;
  logic             r_par_err;

  dmem_parity_gen #(.DATA_W(DATA_W)) u_wpar (.i_data(w_wdata), .o_parity(w_wpar_gen));
  dmem_parity_gen #(.DATA_W(DATA_W)) u_rpar (.i_data(w_rdata), .o_parity(w_rpar_gen));

  // Inject flips only lane 0 so a single known lane can be exercised.
  assign w_wpar = w_wpar_gen ^ LANES'(bus.Par_Inject);

  // Parity storage shadows every array write, including clear.
  always_ff @(posedge Clock) begin
    if (w_we) r_par_mem[w_addr] <= w_wpar;
  end

  // Mismatch flag aligned with Rd_Valid / Host_Ack; data passes unchanged.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_par_err <= 1'b0;
    else       r_par_err <= (w_proc_rd | w_host_rd) && (w_rpar_gen != r_par_mem[w_addr]);
  end

  assign bus.Par_Err = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cardinal_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_cardinal_dmem
// Purpose  : Self-checking bench for cardinal_dmem: clear timing, processor
//            read/write table, host arbitration, drop flag, reset mid-clear.
// Revision : 1.0  initial release
// ============================================================================
module tb_cardinal_dmem;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  cardinal_dmem_if #(.ADDR_W(8), .DATA_W(64)) bus ();

  cardinal_dmem #(.ADDR_W(8), .DATA_W(64), .CLR_PER_CYC(1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [63:0] data;   // write data, or expected read data
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; the scoreboard checks the read result due this cycle.
  task automatic tick();
    logic [63:0] e;
    @(posedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rd_valid", 64'(bus.Rd_Valid), 64'd1);
      check("rd_data", bus.Data_Out, e);
    end else begin
      check("rd_valid_idle", 64'(bus.Rd_Valid), 64'd0);
    end
  endtask

  task automatic proc(input logic we, input logic [7:0] a, input logic [63:0] d, input logic [63:0] exp);
    bus.DmemEn   = 1'b1;
    bus.DmemWrEn = we;
    bus.Mem_Addr = a;
    bus.Data_In  = d;
    if (!we) exp_q.push_back(exp);
    tick();
  endtask

  task automatic idle();
    bus.DmemEn   = 1'b0;
    bus.DmemWrEn = 1'b0;
    tick();
  endtask

  task automatic host_op(input logic we, input logic [7:0] a, input logic [63:0] d,
                         output logic [63:0] rdata, output int lat);
    bus.Host_Req   = 1'b1;
    bus.Host_We    = we;
    bus.Host_Addr  = a;
    bus.Host_Wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.Host_Ack && lat < 64);
    check("host_ack_seen", 64'(bus.Host_Ack), 64'd1);
    rdata = bus.Host_Rdata;
    bus.Host_Req = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.Ready && n < 400) begin
      check("host_ack_during_clear", 64'(bus.Host_Ack), 64'd0);
      tick();
      n++;
    end
    check(name, 64'(n), 64'd256);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int lat;
    int n;

    bus.DmemEn = 0; bus.DmemWrEn = 0; bus.Mem_Addr = 0; bus.Data_In = 0;
    bus.Host_Req = 0; bus.Host_We = 0; bus.Host_Addr = 0; bus.Host_Wdata = 0;
`ifdef CARDINAL_DMEM_PARITY_EN
    bus.Par_Inject = 0;
`endif

    tbl[0]  = '{1'b1, 8'h10, 64'hDEADBEEF_01234567};
    tbl[1]  = '{1'b0, 8'h10, 64'hDEADBEEF_01234567};
    tbl[2]  = '{1'b1, 8'hFF, 64'h01234567_89ABCDEF};
    tbl[3]  = '{1'b1, 8'h00, 64'hFFFFFFFF_FFFFFFFF};
    tbl[4]  = '{1'b0, 8'hFF, 64'h01234567_89ABCDEF};
    tbl[5]  = '{1'b0, 8'h00, 64'hFFFFFFFF_FFFFFFFF};
    tbl[6]  = '{1'b0, 8'h05, 64'h0};
    tbl[7]  = '{1'b1, 8'h10, 64'h1};
    tbl[8]  = '{1'b0, 8'h10, 64'h1};
    tbl[9]  = '{1'b0, 8'h80, 64'h0};
    tbl[10] = '{1'b0, 8'h10, 64'h1};

    // Reset values
    tick();
    check("rst_ready", 64'(bus.Ready), 64'd0);
    check("rst_ack", 64'(bus.Host_Ack), 64'd0);
    check("rst_drop", 64'(bus.Drop_Err), 64'd0);
    check("rst_dout", bus.Data_Out, 64'd0);
    check("rst_hrdata", bus.Host_Rdata, 64'd0);
    Reset = 1'b0;

    // Clear timing, with a dropped write to 0x05 at cycle 10
    n = 0;
    while (!bus.Ready && n < 400) begin
      bus.DmemEn   = (n == 10);
      bus.DmemWrEn = (n == 10);
      bus.Mem_Addr = 8'h05;
      bus.Data_In  = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      n++;
      if (n == 11) check("drop_err_set", 64'(bus.Drop_Err), 64'd1);
    end
    check("ready_latency", 64'(n), 64'd256);
    bus.DmemEn = 0; bus.DmemWrEn = 0;

    // Host read of a cleared word
    host_op(1'b0, 8'h7F, 64'h0, rd, lat);
    check("host_rd_7f", rd, 64'd0);
    check("host_rd_lat", 64'(lat), 64'd2);
    idle();

    // Processor vector table, back to back
    for (int i = 0; i < 11; i++) proc(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].data);
    idle();
    check("dout_hold", bus.Data_Out, 64'd1);

    // Host write deferred while the processor keeps DmemEn high in HOST
    bus.Host_Req = 1'b1; bus.Host_We = 1'b1;
    bus.Host_Addr = 8'h55; bus.Host_Wdata = {4{16'hA5A5}};
    idle();
    check("ack_not_yet", 64'(bus.Host_Ack), 64'd0);
    for (int i = 0; i < 3; i++) begin
      proc(1'b0, 8'h10, 64'h0, 64'h1);
      check("ack_deferred", 64'(bus.Host_Ack), 64'd0);
    end
    idle();
    check("host_wr_ack", 64'(bus.Host_Ack), 64'd1);
    bus.Host_Req = 1'b0;
    idle();
    check("ack_one_pulse", 64'(bus.Host_Ack), 64'd0);
    proc(1'b0, 8'h55, 64'h0, {4{16'hA5A5}});
    idle();
    host_op(1'b0, 8'h55, 64'h0, rd, lat);
    check("host_rd_55", rd, {4{16'hA5A5}});
    idle();

    // Reset in the middle of clear
    check("drop_sticky", 64'(bus.Drop_Err), 64'd1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    Reset = 1'b1;
    tick();
    check("rst2_ready", 64'(bus.Ready), 64'd0);
    check("rst2_drop", 64'(bus.Drop_Err), 64'd0);
    Reset = 1'b0;
    wait_ready("ready_latency2");
    proc(1'b0, 8'h10, 64'h0, 64'h0);
    proc(1'b0, 8'h55, 64'h0, 64'h0);
    idle();

`ifdef CARDINAL_DMEM_PARITY_EN
    bus.Par_Inject = 1'b1;
    proc(1'b1, 8'h20, 64'hFF, 64'h0);
    bus.Par_Inject = 1'b0;
    proc(1'b0, 8'h20, 64'h0, 64'hFF);
    check("par_err_inject", 64'(bus.Par_Err), 64'd1);
    idle();
    check("par_err_pulse", 64'(bus.Par_Err), 64'd0);
    proc(1'b1, 8'h21, 64'hFF, 64'h0);
    proc(1'b0, 8'h21, 64'h0, 64'hFF);
    check("par_err_clean", 64'(bus.Par_Err), 64'd0);
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
